// File: rtl/axi_rd_master.sv
// AXI read master: splits a user read request into AXI bursts of at most
// RBURST_LEN beats, issues them one at a time, forwards every returned beat
// to the user side and flags rlast disagreements with the beat count.
//
// Handshakes: a transfer on any channel happens at the clk edge where valid
// and ready are both 1. The master never drops arvalid, araddr or arlen once
// raised until that edge. axi_rready is high for the whole R state, so every
// rvalid seen in R is a completed beat.
module axi_rd_master #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_LEVEL = 2,
  parameter int RBURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  rd_trig,
  input  logic [7:0]            rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_en,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic                  axi_rlast,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Burst limit widened to 9 bits so RBURST_LEN=256 compares correctly.
  localparam logic [8:0] LP_BURST = 9'(RBURST_LEN);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_cur_addr;
  logic [7:0]              r_remaining;
  logic [7:0]              r_beats;
  logic [7:0]              r_beat_cnt;
  logic [7:0]              r_arlen;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_data_en;
  logic                    r_rd_done;
  logic                    r_rd_err;

  logic                    w_accept;
  logic                    w_r_hs;
  logic                    w_last_beat;
  logic                    w_burst_end;
  logic                    w_load;
  logic                    w_rlast_bad;
  logic [ADDR_WIDTH-1:0]   w_step;
  logic [ADDR_WIDTH-1:0]   w_src_addr;
  logic [7:0]              w_src_rem;
  logic [7:0]              w_src_beats;

  assign w_accept    = rd_trig && rd_ready;
  assign w_r_hs      = (r_state == S_R) && axi_rvalid;
  assign w_last_beat = (r_beat_cnt == r_beats - 8'd1);
  assign w_burst_end = w_r_hs && w_last_beat;
  assign w_rlast_bad = w_r_hs && (axi_rlast != w_last_beat);
  assign w_load      = w_accept || w_burst_end;

  // Address/length of the next burst: from the request when idle, otherwise
  // advanced past the burst that is finishing now (wraps at 2^ADDR_WIDTH).
  assign w_step      = ADDR_WIDTH'(r_beats) * ADDR_WIDTH'(DATA_LEVEL);
  assign w_src_addr  = (r_state == S_IDLE) ? rd_addr : r_cur_addr + w_step;
  assign w_src_rem   = (r_state == S_IDLE) ? rd_len  : r_remaining - r_beats;
  assign w_src_beats = ({1'b0, w_src_rem} < LP_BURST) ? w_src_rem : LP_BURST[7:0];

  assign rd_data     = r_rd_data;
  assign rd_data_en  = r_rd_data_en;
  assign rd_done     = r_rd_done;
  assign rd_err      = r_rd_err;
  assign axi_araddr  = r_cur_addr;
  assign axi_arlen   = r_arlen;
  assign dbg_state   = r_state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and state-decoded outputs; rd_ready is masked during reset.
  always_comb begin
    w_next      = r_state;
    rd_ready    = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        rd_ready = init_end && !rst;
        if (rd_trig && init_end) w_next = (rd_len == 8'd0) ? S_DONE : S_AR;
      end
      S_AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) w_next = S_R;
      end
      S_R: begin
        axi_rready = 1'b1;
        if (w_burst_end) w_next = (w_src_rem != 8'd0) ? S_AR : S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: burst bookkeeping, beat forwarding, done pulse, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_beats      <= '0;
      r_beat_cnt   <= '0;
      r_arlen      <= '0;
      r_rd_data    <= '0;
      r_rd_data_en <= 1'b0;
      r_rd_done    <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      r_rd_data_en <= w_r_hs;
      if (w_r_hs) r_rd_data <= axi_rdata;
      // Registered from DONE so the pulse lands after the last data beat.
      r_rd_done <= (r_state == S_DONE);
      if (w_accept)         r_rd_err <= 1'b0;
      else if (w_rlast_bad) r_rd_err <= 1'b1;
      if (w_load) begin
        r_cur_addr  <= w_src_addr;
        r_remaining <= w_src_rem;
        r_beats     <= w_src_beats;
        r_arlen     <= w_src_beats - 8'd1;
        r_beat_cnt  <= '0;
      end else if (w_r_hs) begin
        r_beat_cnt  <= r_beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: a table of read requests with
// hand-computed AR sequences, driven by a small AXI slave, plus hand-written
// gating and mid-burst reset sequences.
module tb_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_end;
  logic        rd_trig;
  logic [7:0]  rd_len;
  logic [25:0] rd_addr;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_data_en;
  logic        rd_done;
  logic        rd_err;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [25:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        axi_rlast;
  logic [31:0] axi_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  axi_rd_master dut (
    .clk(clk), .rst(rst), .init_end(init_end), .rd_trig(rd_trig),
    .rd_len(rd_len), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_en(rd_data_en), .rd_done(rd_done),
    .rd_err(rd_err), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] addr;
    logic [7:0]  len;
    int          stall;     // arready-low cycles before each AR is taken
    bit          toggle;    // rvalid only every other cycle
    int          bad_beat;  // 1-based beat whose rlast is inverted, 0 = none
    bit          drop_init; // drop init_end after accept
    int          nar;
    logic [25:0] a0, a1, a2;
    logic [7:0]  l0, l1, l2;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One request end to end, with the bench acting as the AXI slave.
  task automatic run_vec(input int id, input vec_t v);
    int nar = 0, ndata = 0, ndone = 0, pend = 0, gbeat = 0, tail = 0, stall;
    bit finished = 0, phase = 0, held = 0;
    logic [25:0] held_addr;
    logic [7:0]  held_len;
    logic [25:0] got_addr[3];
    logic [7:0]  got_len[3];
    logic [25:0] ea[3];
    logic [7:0]  el[3];
    logic [31:0] dval = 32'd1;
    ea = '{v.a0, v.a1, v.a2};
    el = '{v.l0, v.l1, v.l2};
    exp_q.delete();
    @(negedge clk);
    check($sformatf("v%0d_ready_before", id), rd_ready, 1);
    rd_trig = 1; rd_addr = v.addr; rd_len = v.len;
    stall = v.stall;
    for (int cyc = 0; cyc < 600 && tail < 6; cyc++) begin
      @(negedge clk);
      rd_trig = 0;
      if (v.drop_init) init_end = 0;
      if (rd_data_en) begin
        ndata++;
        if (exp_q.size() == 0) check($sformatf("v%0d_extra_beat", id), 1, 0);
        else check($sformatf("v%0d_rd_data", id), rd_data, exp_q.pop_front());
      end
      if (rd_done) begin
        ndone++;
        check($sformatf("v%0d_data_before_done", id), ndata, v.len);
        finished = 1;
      end
      if (finished) tail++;
      axi_arready = 0;
      if (axi_arvalid) begin
        if (held) begin
          check($sformatf("v%0d_araddr_stable", id), axi_araddr, held_addr);
          check($sformatf("v%0d_arlen_stable", id), axi_arlen, held_len);
        end
        if (stall > 0) begin
          stall--; held = 1; held_addr = axi_araddr; held_len = axi_arlen;
        end else begin
          axi_arready = 1; held = 0;
          if (nar < 3) begin got_addr[nar] = axi_araddr; got_len[nar] = axi_arlen; end
          nar++;
          pend = int'(axi_arlen) + 1;
          stall = v.stall;
        end
      end
      axi_rvalid = 0; axi_rlast = 0;
      phase = ~phase;
      if (axi_rready && pend > 0 && (!v.toggle || phase)) begin
        gbeat++;
        axi_rvalid = 1; axi_rdata = dval;
        exp_q.push_back(dval);
        dval++;
        axi_rlast = (pend == 1);
        if (gbeat == v.bad_beat) axi_rlast = !axi_rlast;
        pend--;
      end
    end
    check($sformatf("v%0d_finished_in_budget", id), finished, 1);
    check($sformatf("v%0d_done_count", id), ndone, 1);
    check($sformatf("v%0d_beat_count", id), ndata, v.len);
    check($sformatf("v%0d_leftover", id), exp_q.size(), 0);
    check($sformatf("v%0d_ar_count", id), nar, v.nar);
    for (int i = 0; i < 3; i++) begin
      if (i < v.nar && i < nar) begin
        check($sformatf("v%0d_araddr%0d", id, i), got_addr[i], ea[i]);
        check($sformatf("v%0d_arlen%0d", id, i), got_len[i], el[i]);
      end
    end
    check($sformatf("v%0d_rd_err", id), rd_err, v.err);
    check($sformatf("v%0d_ready_after", id), rd_ready, !v.drop_init);
    init_end = 1;
  endtask

  initial begin
    int k, n;
    //          addr        len    stall tog bad drop nar a0          a1          a2       l0     l1     l2     err
    vecs[0] = '{26'h100,     8'd8,  0, 0, 0, 0, 1, 26'h100,     26'h0,   26'h0,  8'd7,  8'd0,  8'd0,  1'b0};
    vecs[1] = '{26'h0,       8'd20, 0, 0, 0, 1, 3, 26'h0,       26'd16,  26'd32, 8'd7,  8'd7,  8'd3,  1'b0};
    vecs[2] = '{26'h40,      8'd12, 5, 1, 0, 0, 2, 26'h40,      26'h50,  26'h0,  8'd7,  8'd3,  8'd0,  1'b0};
    vecs[3] = '{26'h200,     8'd0,  0, 0, 0, 0, 0, 26'h0,       26'h0,   26'h0,  8'd0,  8'd0,  8'd0,  1'b0};
    vecs[4] = '{26'h3FFFFFC, 8'd8,  0, 0, 0, 0, 1, 26'h3FFFFFC, 26'h0,   26'h0,  8'd7,  8'd0,  8'd0,  1'b0};
    vecs[5] = '{26'h3FFFFFC, 8'd12, 0, 0, 0, 0, 2, 26'h3FFFFFC, 26'hC,   26'h0,  8'd7,  8'd3,  8'd0,  1'b0};
    vecs[6] = '{26'h80,      8'd8,  0, 0, 3, 0, 1, 26'h80,      26'h0,   26'h0,  8'd7,  8'd0,  8'd0,  1'b1};
    vecs[7] = '{26'h10,      8'd3,  0, 1, 3, 0, 1, 26'h10,      26'h0,   26'h0,  8'd2,  8'd0,  8'd0,  1'b1};
    vecs[8] = '{26'h20,      8'd1,  0, 0, 0, 0, 1, 26'h20,      26'h0,   26'h0,  8'd0,  8'd0,  8'd0,  1'b0};

    // Reset.
    rst = 1; init_end = 0; rd_trig = 0; rd_len = 0; rd_addr = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rdata = 0;
    repeat (3) @(negedge clk);
    check("reset_state", dbg_state, 0);
    check("reset_outs", {axi_arvalid, axi_rready, rd_data_en, rd_done, rd_err, rd_ready}, 0);
    check("reset_data", {rd_data, axi_araddr, axi_arlen}, 0);
    rst = 0;

    // Requests while init_end=0 are ignored and not remembered.
    n = 0;
    rd_trig = 1; rd_addr = 26'h300; rd_len = 8'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_ready || axi_arvalid || dbg_state != 0) n++;
    end
    rd_trig = 0; init_end = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (axi_arvalid || rd_done || rd_data_en) n++;
    end
    check("gated_trig_ignored", n, 0);
    check("ready_after_init", rd_ready, 1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the middle of R, with rd_err already set by an early rlast.
    @(negedge clk);
    rd_trig = 1; rd_addr = 26'h0; rd_len = 8'd8;
    @(negedge clk);
    rd_trig = 0;
    k = 0;
    while (!axi_arvalid && k < 20) begin @(negedge clk); k++; end
    check("rst_seq_arvalid", axi_arvalid, 1);
    axi_arready = 1;
    @(negedge clk);
    axi_arready = 0;
    for (int b = 0; b < 3; b++) begin
      axi_rvalid = 1; axi_rdata = 32'hA0 + b; axi_rlast = (b == 0);
      @(negedge clk);
    end
    axi_rvalid = 0; axi_rlast = 0;
    check("rst_seq_err_before", rd_err, 1);
    check("rst_seq_in_r", axi_rready, 1);
    rst = 1;
    #1;
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_outs", {axi_arvalid, axi_rready, rd_data_en, rd_done, rd_err, rd_ready}, 0);
    check("rst_mid_data", {rd_data, axi_araddr, axi_arlen}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi_arvalid || rd_done || rd_data_en) n++;
    end
    check("rst_no_residue", n, 0);
    run_vec(9, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
